// File: rtl/bcd_display_scan.sv
// Captures packed BCD digits into a shadow register and scans them onto a common-anode
// seven-segment display. Optional leading-zero blanking: define BCD_SCAN_LZB_EN.
module bcd_display_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iLoad,
  input  logic [4*DIGITS-1:0]   iBcd,
  input  logic                  iOvf,
  input  logic                  iClrOvf,
  output logic [DIGITS-1:0]     oAn,
  output logic [6:0]            oSeg,
  output logic                  oDp
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    prescaleCnt;
  logic [IDX_W-1:0]    digitSel;
  logic [4*DIGITS-1:0] shadowReg;
  logic                stickyOvf;
  logic                tick;
  logic [3:0]          selNibble;
  logic [6:0]          segNext;
  logic [DIGITS-1:0]   anNext;
  logic                blankSel;

  function automatic logic [6:0] decodeSeg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h3F;
    endcase
    return seg;
  endfunction

  assign tick = (prescaleCnt == LAST_CNT);

  // digitSel names the digit the next tick will light
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : gAnode
      assign anNext[gi] = (digitSel != IDX_W'(gi));
    end
  endgenerate

`ifdef BCD_SCAN_LZB_EN
  logic [DIGITS-1:0] blankVec;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : gBlank
      if (gi == 0) begin : gFirst
        assign blankVec[gi] = 1'b0;
      end else begin : gUpper
        assign blankVec[gi] = (shadowReg[4*DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate
`endif

  always_comb begin
    selNibble = '0;
    blankSel  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digitSel == IDX_W'(i)) begin
        selNibble = shadowReg[4*i +: 4];
`ifdef BCD_SCAN_LZB_EN
        blankSel  = blankVec[i];
`endif
      end
    end
    segNext = blankSel ? 7'h7F : decodeSeg(selNibble);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      prescaleCnt <= '0;
      digitSel    <= '0;
      shadowReg   <= '0;
      stickyOvf   <= 1'b0;
      oAn         <= '1;
      oSeg        <= 7'h7F;
      oDp         <= 1'b1;
    end else begin
      if (iLoad) begin
        shadowReg <= iBcd;
      end
      if (iOvf) begin
        stickyOvf <= 1'b1;
      end else if (iClrOvf) begin
        stickyOvf <= 1'b0;
      end
      // outputs only move on the tick edge, so a load mid-slot waits for the next slot
      if (tick) begin
        prescaleCnt <= '0;
        oAn         <= anNext;
        oSeg        <= segNext;
        oDp         <= (digitSel == '0) ? ~stickyOvf : 1'b1;
        digitSel    <= (digitSel == LAST_IDX) ? '0 : digitSel + IDX_W'(1);
      end else begin
        prescaleCnt <= prescaleCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan (DIGITS=4, SCAN_DIV=4) with a per-slot scoreboard.
module tb_bcd_display_scan;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iLoad;
  logic [15:0] iBcd;
  logic        iOvf;
  logic        iClrOvf;
  logic [3:0]  oAn;
  logic [6:0]  oSeg;
  logic        oDp;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t expq[$];

  bcd_display_scan #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .iClk(iClk), .iRst(iRst), .iLoad(iLoad), .iBcd(iBcd),
    .iOvf(iOvf), .iClrOvf(iClrOvf), .oAn(oAn), .oSeg(oSeg), .oDp(oDp)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] segModel(input logic [3:0] n);
    logic [6:0] table16 [16];
    table16 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    return table16[n];
  endfunction

  task automatic pushSlot(input int d, input logic [15:0] bcd, input logic sticky);
    slot_t e;
    logic [3:0] one;
    one   = 4'b0001;
    e.an  = ~(one << d);
    e.seg = segModel(bcd[4*d +: 4]);
`ifdef BCD_SCAN_LZB_EN
    if (d > 0 && (bcd >> (4*d)) == 16'h0) e.seg = 7'h7F;
`endif
    e.dp  = (d == 0) ? ~sticky : 1'b1;
    expq.push_back(e);
  endtask

  task automatic pushFrame(input logic [15:0] bcd, input logic sticky);
    for (int d = 0; d < 4; d++) pushSlot(d, bcd, sticky);
  endtask

  task automatic checkBlank(input string tag);
    check({tag, ".an"}, 32'(oAn), 32'h0000000F);
    check({tag, ".seg"}, 32'(oSeg), 32'h0000007F);
    check({tag, ".dp"}, 32'(oDp), 32'h00000001);
  endtask

  task automatic clearInputs();
    iLoad   = 1'b0;
    iOvf    = 1'b0;
    iClrOvf = 1'b0;
  endtask

  task automatic runBlank(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge iClk); #1;
      checkBlank($sformatf("%s.c%0d", tag, c));
      clearInputs();
    end
  endtask

  task automatic popExp(input string tag, output slot_t e);
    total++;
    assert (expq.size() != 0) else begin
      bad++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (expq.size() != 0) e = expq.pop_front();
    else e = '{4'hF, 7'h7F, 1'b1};
  endtask

  // Entered with the next edge being a tick; consumes one full 4-cycle slot.
  task automatic runSlot(input string tag, input logic doLoad, input logic [15:0] loadVal,
                         input logic doOvf, input logic doClr);
    slot_t e;
    popExp(tag, e);
    for (int c = 0; c < 4; c++) begin
      @(posedge iClk); #1;
      check($sformatf("%s.an.c%0d", tag, c), 32'(oAn), 32'(e.an));
      check($sformatf("%s.seg.c%0d", tag, c), 32'(oSeg), 32'(e.seg));
      check($sformatf("%s.dp.c%0d", tag, c), 32'(oDp), 32'(e.dp));
      iLoad   = (c == 1) && doLoad;
      iOvf    = (c == 1) && doOvf;
      iClrOvf = (c == 1) && doClr;
      if (c == 1 && doLoad) iBcd = loadVal;
    end
    $display("slot %s an=%h seg=%h dp=%b", tag, oAn, oSeg, oDp);
  endtask

  initial begin
    slot_t e;
    iRst = 1'b1;
    iBcd = 16'h0;
    clearInputs();
    for (int c = 0; c < 3; c++) begin
      @(posedge iClk); #1;
      checkBlank($sformatf("reset.c%0d", c));
    end
    iRst  = 1'b0;
    iLoad = 1'b1;
    iBcd  = 16'h1234;
    runBlank("prefirst", 3);

    pushFrame(16'h1234, 1'b0);
    runSlot("f1234.d0", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("f1234.d1", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("f1234.d2", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("f1234.d3", 1'b1, 16'h00A9, 1'b0, 1'b0);

    pushFrame(16'h00A9, 1'b0);
    runSlot("f00A9.d0", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("f00A9.d1", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("f00A9.d2", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("f00A9.d3", 1'b1, 16'h0070, 1'b1, 1'b0);

    pushFrame(16'h0070, 1'b1);
    runSlot("ovf.d0", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("ovf.d1", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("ovf.d2", 1'b0, 16'h0, 1'b1, 1'b1);
    runSlot("ovf.d3", 1'b0, 16'h0, 1'b0, 1'b0);

    pushFrame(16'h0070, 1'b1);
    runSlot("both.d0", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("both.d1", 1'b0, 16'h0, 1'b0, 1'b1);
    runSlot("both.d2", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("both.d3", 1'b0, 16'h0, 1'b0, 1'b0);

    pushFrame(16'h0070, 1'b0);
    runSlot("clr.d0", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("clr.d1", 1'b0, 16'h0, 1'b0, 1'b0);

    // digit 2 is lit: check one cycle, then reset mid-slot
    popExp("mid.d2", e);
    @(posedge iClk); #1;
    check("mid.d2.an", 32'(oAn), 32'(e.an));
    check("mid.d2.seg", 32'(oSeg), 32'(e.seg));
    iRst = 1'b1;
    @(posedge iClk); #1;
    checkBlank("midrst");
    $display("slot midrst an=%h seg=%h dp=%b", oAn, oSeg, oDp);
    iRst = 1'b0;
    expq.delete();
    runBlank("postrst", 3);

    // load lands on the tick edge: that slot still shows the old (reset) shadow
    iLoad = 1'b1;
    iBcd  = 16'h5678;
    pushSlot(0, 16'h0000, 1'b0);
    pushSlot(1, 16'h5678, 1'b0);
    pushSlot(2, 16'h5678, 1'b0);
    pushSlot(3, 16'h5678, 1'b0);
    pushSlot(0, 16'h5678, 1'b0);
    runSlot("tickld.d0", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("tickld.d1", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("tickld.d2", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("tickld.d3", 1'b0, 16'h0, 1'b0, 1'b0);
    runSlot("tickld.d0b", 1'b0, 16'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
